rob_commit_unit: RTL and testbench
==================================

ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

Interface
REQ-001 Parameter ROB_DEPTH, default 8, entry count; power of two, >= 4.
REQ-002 Parameter NUM_REGS, default 16, architectural register count.
REQ-003 Parameter DATA_W, default 32, value width.
REQ-004 Parameter COMMIT_W, default 2, maximum commits per cycle; range 1..4.
REQ-005 Derived widths: TAG_W = log2(ROB_DEPTH), REG_W = log2(NUM_REGS).
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 alloc_valid  in  1  dispatch requests one entry.
REQ-010 alloc_dest  in  REG_W  destination register.
REQ-011 alloc_ready  out  1  entry available.
REQ-012 alloc_tag  out  TAG_W  tag given to the allocation, equal to the tail pointer.
REQ-013 wb_valid  in  1  CDB broadcast.
REQ-014 wb_tag  in  TAG_W  producing entry.
REQ-015 wb_value  in  DATA_W  result.
REQ-016 flush  in  1  discard all in-flight entries.
REQ-017 rf_we  out  COMMIT_W  per-slot register-file write enable; slot 0 is oldest.
REQ-018 rf_waddr  out  COMMIT_W*REG_W  packed addresses.
REQ-019 rf_wdata  out  COMMIT_W*DATA_W  packed data.
REQ-020 rename_busy  out  NUM_REGS  register has an in-flight producer.
REQ-021 rob_count  out  TAG_W+1  occupied entries.
REQ-022 rob_empty  out  1  rob_count == 0.

Function
REQ-023 Storage: a circular buffer with head, tail and count; each entry holds valid, ready, dest and value.
REQ-024 Allocation: alloc_ready = (count < ROB_DEPTH), with no look-ahead on same-cycle commits.
REQ-025 Allocation completes when alloc_valid && alloc_ready; it writes the entry at tail (valid=1, ready=0) and increments tail modulo ROB_DEPTH.
REQ-026 Allocation also sets rename_tag[alloc_dest] = tail and rename_busy[alloc_dest] = 1.
REQ-027 Writeback: when wb_valid and entry[wb_tag] is valid and not ready, the block stores wb_value and sets ready=1.
REQ-028 Writeback is ignored when wb_tag names an invalid entry or an already-ready entry.
REQ-029 Writeback is ignored when wb_tag equals the tag being allocated in the same cycle.
REQ-030 Commit, evaluated each edge: the block commits k entries starting at head, where k is the largest k <= COMMIT_W such that entries head..head+k-1 are all valid and ready.
REQ-031 Commit stops at the first entry that is not ready; there is no out-of-order commit.
REQ-032 Commit outputs are registered: slot i is presented in the cycle after the edge at which entry i committed; rf_we is low in all slots otherwise.
REQ-033 Minimum latency: a wb at edge N produces rf_we at edge N+1, i.e. the write is visible during cycle N+1.
REQ-034 Committed entries: valid is cleared, head advances by k modulo ROB_DEPTH, and count is updated as count + alloc - k.
REQ-035 Same-destination commits: when two committing slots share a destination, only the youngest such slot asserts rf_we.
REQ-036 Rename clear: when a committing entry's tag equals rename_tag[dest], rename_busy[dest] is cleared.
REQ-037 Rename priority: a same-cycle allocation to the same dest takes priority, leaving busy=1 with the new tag.
REQ-038 Wrap-around: head, tail and wb_tag indexing wrap modulo ROB_DEPTH; full and empty are distinguished by count only.
REQ-039 Flush clears, at the next edge, all valid bits, head, tail, count and rename_busy, and forces rf_we to 0.
REQ-040 Flush overrides alloc, wb and commit in the same cycle, and entries ready at that edge do not commit.

Reset
REQ-041 While rst is high, the block clears asynchronously: head=tail=count=0, all valid/ready=0, rename_busy=0 and rf_we=0.
REQ-042 Reset values: alloc_ready=1, alloc_tag=0, rob_empty=1, rob_count=0, rf_waddr=0, rf_wdata=0.
REQ-043 Reset asserted mid-operation discards in-flight entries with no rf write, and the first allocation after release returns tag 0.

Verification
REQ-044 Defaults: alloc dest r3, r5; wb tag1=0x22, then tag0=0x11 -> single cycle with rf_we=2'b11, waddr {5,3}, wdata {0x22,0x11}; busy r3/r5 cleared.
REQ-045 Allocate 8 entries -> alloc_ready=0 and count=8; wb all, then allocate again while committing -> refused until count<8; tags wrap to 0.
REQ-046 Allocate r4 twice as tags 0,1; wb both -> only slot 1 writes r4 (data of tag 1); rename_busy[4]=0.
REQ-047 Tag 0 not ready while tags 1-3 are ready -> no rf_we; wb tag 0 -> commit of tags 0,1 in one cycle, then tags 2,3 the next.
REQ-048 Flush with 5 valid entries, 2 of them ready -> no rf_we, count=0, rename_busy=0, next alloc_tag equals the pre-flush tail reset to 0.
REQ-049 Assert rst asynchronously between edges with 3 entries -> outputs reach reset values before the next edge, and stale wb values are never committed.

Source files
------------

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order, multi-slot commit.
// Tracks rename state and drives registered register-file writes.
module rob_commit_unit #(
  parameter int ROB_DEPTH = 8,
  parameter int NUM_REGS  = 16,
  parameter int DATA_W    = 32,
  parameter int COMMIT_W  = 2,
  localparam int TAG_W    = $clog2(ROB_DEPTH),
  localparam int REG_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  input  logic [REG_W-1:0]           alloc_dest,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic                       wb_valid,
  input  logic [TAG_W-1:0]           wb_tag,
  input  logic [DATA_W-1:0]          wb_value,
  input  logic                       flush,
  output logic [COMMIT_W-1:0]        rf_we,
  output logic [COMMIT_W*REG_W-1:0]  rf_waddr,
  output logic [COMMIT_W*DATA_W-1:0] rf_wdata,
  output logic [NUM_REGS-1:0]        rename_busy,
  output logic [TAG_W:0]             rob_count,
  output logic                       rob_empty
);

  logic [ROB_DEPTH-1:0]      r_valid;
  logic [ROB_DEPTH-1:0]      r_ready;
  logic [REG_W-1:0]          r_dest [ROB_DEPTH];
  logic [DATA_W-1:0]         r_value [ROB_DEPTH];
  logic [TAG_W-1:0]          r_rtag [NUM_REGS];
  logic [NUM_REGS-1:0]       r_busy;
  logic [TAG_W-1:0]          r_head;
  logic [TAG_W-1:0]          r_tail;
  logic [TAG_W:0]            r_count;
  logic [COMMIT_W-1:0]       r_rf_we;
  logic [COMMIT_W*REG_W-1:0] r_rf_waddr;
  logic [COMMIT_W*DATA_W-1:0] r_rf_wdata;

  logic                      w_alloc;
  logic                      w_wb;
  logic [TAG_W-1:0]          w_idx [COMMIT_W];
  logic [COMMIT_W-1:0]       w_commit;
  logic [COMMIT_W-1:0]       w_we;
  logic [TAG_W:0]            w_k;
  logic                      w_run;

  assign alloc_ready = r_count < (TAG_W+1)'(ROB_DEPTH);
  assign alloc_tag   = r_tail;
  assign rob_count   = r_count;
  assign rob_empty   = (r_count == '0);
  assign rename_busy = r_busy;
  assign rf_we       = r_rf_we;
  assign rf_waddr    = r_rf_waddr;
  assign rf_wdata    = r_rf_wdata;

  // Allocation and writeback qualification; flush suppresses both.
  assign w_alloc = alloc_valid && alloc_ready && !flush;
  assign w_wb = wb_valid && !flush &&
                r_valid[wb_tag] && !r_ready[wb_tag] &&
                !(w_alloc && (wb_tag == r_tail));

  // Commit window: longest ready prefix starting at head.
  always_comb begin
    w_commit = '0;
    w_k      = '0;
    w_run    = 1'b1;
    for (int i = 0; i < COMMIT_W; i++) begin
      w_idx[i]    = r_head + TAG_W'(i);
      w_run       = w_run && r_valid[w_idx[i]] && r_ready[w_idx[i]];
      w_commit[i] = w_run;
      w_k         = w_k + (TAG_W+1)'(w_run);
    end
  end

  // Only the youngest committing slot per destination writes.
  always_comb begin
    w_we = w_commit;
    for (int i = 0; i < COMMIT_W; i++) begin
      for (int j = i + 1; j < COMMIT_W; j++) begin
        if (w_commit[j] && r_dest[w_idx[j]] == r_dest[w_idx[i]])
          w_we[i] = 1'b0;
      end
    end
  end

  // Entry payload and rename tags; no reset needed.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_dest[r_tail]     <= alloc_dest;
      r_rtag[alloc_dest] <= r_tail;
    end
    if (w_wb)
      r_value[wb_tag] <= wb_value;
  end

  // Control state, rename busy bits and registered commit outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_ready    <= '0;
      r_busy     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rf_we    <= '0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (flush) begin
      r_valid    <= '0;
      r_ready    <= '0;
      r_busy     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rf_we    <= '0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      for (int i = 0; i < COMMIT_W; i++) begin
        if (w_commit[i]) begin
          r_valid[w_idx[i]] <= 1'b0;
          r_ready[w_idx[i]] <= 1'b0;
          if (r_rtag[r_dest[w_idx[i]]] == w_idx[i])
            r_busy[r_dest[w_idx[i]]] <= 1'b0;
          r_rf_waddr[i*REG_W +: REG_W]   <= r_dest[w_idx[i]];
          r_rf_wdata[i*DATA_W +: DATA_W] <= r_value[w_idx[i]];
        end else begin
          r_rf_waddr[i*REG_W +: REG_W]   <= '0;
          r_rf_wdata[i*DATA_W +: DATA_W] <= '0;
        end
      end
      r_rf_we <= w_we;
      if (w_wb)
        r_ready[wb_tag] <= 1'b1;
      if (w_alloc) begin
        r_valid[r_tail]    <= 1'b1;
        r_ready[r_tail]    <= 1'b0;
        r_busy[alloc_dest] <= 1'b1;
        r_tail             <= r_tail + TAG_W'(1);
      end
      r_head  <= r_head + w_k[TAG_W-1:0];
      r_count <= r_count + {{TAG_W{1'b0}}, w_alloc} - w_k;
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit, default parameters.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [31:0] wb_value;
  logic        flush;
  logic [1:0]  rf_we;
  logic [7:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [15:0] rename_busy;
  logic [3:0]  rob_count;
  logic        rob_empty;

  int checks = 0;
  int errors = 0;

  rob_commit_unit dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rename_busy(rename_busy), .rob_count(rob_count),
    .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_dest = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_value = '0;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [3:0] d);
    alloc_valid = 1'b1; alloc_dest = d;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] t, input logic [31:0] v);
    wb_valid = 1'b1; wb_tag = t; wb_value = v;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_count", rob_count, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", rename_busy, 0);

    // Basic two-wide commit, writebacks out of order
    alloc(4'd3);
    chk("b_tag1", alloc_tag, 1);
    alloc(4'd5);
    chk("b_busy", rename_busy, 16'h0028);
    chk("b_count", rob_count, 2);
    wb(3'd1, 32'h22);
    chk("b_nowe", rf_we, 0);
    wb(3'd0, 32'h11);
    chk("b_nowe2", rf_we, 0);
    tick();
    chk("b_we", rf_we, 2'b11);
    chk("b_waddr", rf_waddr, 8'h53);
    chk("b_wdata", rf_wdata, 64'h00000022_00000011);
    chk("b_busy0", rename_busy, 0);
    chk("b_empty", rob_empty, 1);
    tick();
    chk("b_we_off", rf_we, 0);

    // Fill, refuse while full, wrap tags
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alloc_dest = 4'(i);
      chk("f_tag", alloc_tag, 64'(i));
      tick();
    end
    alloc_valid = 1'b0;
    chk("f_full", alloc_ready, 0);
    chk("f_count", rob_count, 8);
    for (int i = 7; i >= 0; i--) wb(3'(i), 32'h200 + 32'(i));
    chk("f_full2", alloc_ready, 0);
    chk("f_count2", rob_count, 8);
    alloc_valid = 1'b1; alloc_dest = 4'd9;
    tick();
    chk("f_refused", rob_count, 6);
    chk("f_we", rf_we, 2'b11);
    chk("f_wdata", rf_wdata, 64'h00000201_00000200);
    chk("f_ready", alloc_ready, 1);
    chk("f_wrap", alloc_tag, 0);
    tick();
    alloc_valid = 1'b0;
    chk("f_count3", rob_count, 5);
    chk("f_tag_after", alloc_tag, 1);
    chk("f_busy9", rename_busy[9], 1);

    // Same destination in both slots
    do_reset();
    alloc(4'd4);
    alloc(4'd4);
    wb(3'd1, 32'hA1);
    wb(3'd0, 32'hA0);
    tick();
    chk("d_we", rf_we, 2'b10);
    chk("d_waddr1", rf_waddr[7:4], 4);
    chk("d_wdata1", rf_wdata[63:32], 32'hA1);
    chk("d_busy", rename_busy, 0);

    // In-order commit blocked by head
    do_reset();
    alloc(4'd1); alloc(4'd2); alloc(4'd3); alloc(4'd6);
    wb(3'd1, 32'h101);
    wb(3'd2, 32'h102);
    wb(3'd3, 32'h103);
    tick();
    chk("o_block", rf_we, 0);
    chk("o_count", rob_count, 4);
    wb(3'd0, 32'h100);
    chk("o_lat", rf_we, 0);
    tick();
    chk("o_we1", rf_we, 2'b11);
    chk("o_waddr1", rf_waddr, 8'h21);
    chk("o_wdata1", rf_wdata, 64'h00000101_00000100);
    tick();
    chk("o_we2", rf_we, 2'b11);
    chk("o_waddr2", rf_waddr, 8'h63);
    chk("o_wdata2", rf_wdata, 64'h00000103_00000102);
    chk("o_busy", rename_busy, 0);
    tick();
    chk("o_idle", rf_we, 0);

    // Flush beats ready entries
    do_reset();
    for (int i = 1; i <= 5; i++) alloc(4'(i));
    wb(3'd1, 32'h31);
    wb(3'd0, 32'h30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("x_we", rf_we, 0);
    chk("x_count", rob_count, 0);
    chk("x_busy", rename_busy, 0);
    chk("x_tag", alloc_tag, 0);
    tick();
    chk("x_we2", rf_we, 0);
    alloc(4'd7);
    chk("x_busy7", rename_busy, 16'h0080);
    chk("x_count1", rob_count, 1);

    // Asynchronous reset between edges
    do_reset();
    alloc(4'd1); alloc(4'd2); alloc(4'd3);
    wb(3'd1, 32'hBAD1);
    wb(3'd2, 32'hBAD2);
    #3;
    rst = 1'b1;
    #1;
    chk("a_count", rob_count, 0);
    chk("a_empty", rob_empty, 1);
    chk("a_ready", alloc_ready, 1);
    chk("a_tag", alloc_tag, 0);
    chk("a_busy", rename_busy, 0);
    chk("a_we", rf_we, 0);
    #2;
    rst = 1'b0;
    tick();
    alloc_valid = 1'b1; alloc_dest = 4'd8;
    wb_valid = 1'b1; wb_tag = 3'd1; wb_value = 32'hDEAD;
    chk("a_tag0", alloc_tag, 0);
    tick();
    alloc_valid = 1'b0;
    wb(3'd0, 32'h55);
    tick();
    chk("a_we1", rf_we, 2'b01);
    chk("a_waddr", rf_waddr, 8'h08);
    chk("a_wdata", rf_wdata, 64'h55);
    tick();
    chk("a_we_off", rf_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
